tx_sequencer: RTL and testbench

Parametrised DAC playback sequencer. Replaces the free-running DAC address counter with a triggered burst engine.
- Generates the playback-RAM address, per-channel sample-valid strobes and the PA enable, with programmable PA lead/lag guard intervals.
- Supports one-shot and continuous (wrapping) burst modes.
- Sits between the control/register block and the RFDC DAC playback memories, clocked on ref_clk.

---
 rtl/tx_seq_pkg.sv | 14 +
 rtl/sync_edge.sv | 20 ++
 rtl/tx_sequencer.sv | 175 +++++++++++++++++
 tb/tb_tx_sequencer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/tx_seq_pkg.sv
// Shared state encoding and default widths for the DAC playback sequencer.
package tx_seq_pkg;
    localparam int DEF_ADDR_W  = 14;
    localparam int DEF_GUARD_W = 8;
    localparam int DEF_NCH     = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_LEAD,
        S_PLAY,
        S_LAG
    } state_t;
endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous level, followed by a registered
// rising-edge pulse (one clk wide).
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic pulse
);
    logic [2:0] sh;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh    <= '0;
            pulse <= 1'b0;
        end else begin
            sh    <= {sh[1:0], d};
            pulse <= sh[1] & ~sh[2];
        end
    end
endmodule

// File: rtl/tx_sequencer.sv
// Triggered DAC playback burst engine: RAM address, per-channel valid and PA
// enable with lead/lag guards. Define TX_SYSREF_ALIGN_EN to hold bursts in ARM until sysref.
module tx_sequencer
    import tx_seq_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int NCH     = DEF_NCH,
    parameter int GUARD_W = DEF_GUARD_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               trig,
    input  logic               mode,
    input  logic [ADDR_W-1:0]  txsmps,
    input  logic [GUARD_W-1:0] lead,
    input  logic [GUARD_W-1:0] lag,
    input  logic [NCH-1:0]     chan_en,
    input  logic               abort,
    input  logic               sysref,
    output logic [ADDR_W-1:0]  tx_addr,
    output logic [NCH-1:0]     tx_valid,
    output logic               pa_en,
    output logic               busy,
    output logic               done,
    output logic               overrun
);
    // One extra bit so a length of 2^ADDR_W is representable.
    localparam int CW = ADDR_W + 1;

    state_t             state, state_d;
    logic [CW-1:0]      len_q, len_d, cnt_q, cnt_d;
    logic [GUARD_W-1:0] gcnt_q, gcnt_d, lead_q, lead_d, lag_q, lag_d;
    logic [NCH-1:0]     chen_q, chen_d;
    logic               mode_q, mode_d;
    logic               enter;

    logic [ADDR_W-1:0]  addr_d;
    logic [NCH-1:0]     valid_d;
    logic               pa_d, busy_d, done_d, ovr_d;

`ifdef TX_SYSREF_ALIGN_EN
    logic sync_pulse;

    sync_edge u_sync (
        .clk   (clk),
        .rst   (rst),
        .d     (sysref),
        .pulse (sync_pulse)
    );
`else
    logic unused_sysref;
    assign unused_sysref = sysref;
`endif

    always_comb begin
        state_d = state;
        len_d   = len_q;
        cnt_d   = cnt_q;
        gcnt_d  = gcnt_q;
        lead_d  = lead_q;
        lag_d   = lag_q;
        chen_d  = chen_q;
        mode_d  = mode_q;
        enter   = 1'b0;
        done_d  = 1'b0;
        ovr_d   = trig && (state != S_IDLE);

        case (state)
            S_IDLE: begin
                if (trig && !abort) begin
                    len_d  = {(txsmps == '0), txsmps};
                    lead_d = lead;
                    lag_d  = lag;
                    chen_d = chan_en;
                    mode_d = mode;
`ifdef TX_SYSREF_ALIGN_EN
                    state_d = S_ARM;
`else
                    enter   = 1'b1;
`endif
                end
            end
`ifdef TX_SYSREF_ALIGN_EN
            S_ARM: begin
                if (abort)           state_d = S_IDLE;
                else if (sync_pulse) enter   = 1'b1;
            end
`endif
            S_LEAD: begin
                if (abort)                state_d = S_IDLE;
                else if (gcnt_q == '0) begin
                    state_d = S_PLAY;
                    cnt_d   = '0;
                end else                  gcnt_d  = gcnt_q - GUARD_W'(1);
            end
            S_PLAY: begin
                if (abort) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == len_q - CW'(1)) begin
                    cnt_d = '0;
                    // Continuous bursts re-check the live mode at every wrap.
                    if (mode_q && mode) begin
                        state_d = S_PLAY;
                    end else if (lag_q != '0) begin
                        state_d = S_LAG;
                        gcnt_d  = lag_q - GUARD_W'(1);
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_LAG: begin
                if (abort)             state_d = S_IDLE;
                else if (gcnt_q == '0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else               gcnt_d  = gcnt_q - GUARD_W'(1);
            end
            default: state_d = S_IDLE;
        endcase

        if (enter) begin
            cnt_d = '0;
            if (lead_d == '0) begin
                state_d = S_PLAY;
            end else begin
                state_d = S_LEAD;
                gcnt_d  = lead_d - GUARD_W'(1);
            end
        end

        busy_d  = (state_d != S_IDLE);
        pa_d    = (state_d == S_LEAD) || (state_d == S_PLAY) || (state_d == S_LAG);
        valid_d = (state_d == S_PLAY) ? chen_d : '0;
        addr_d  = (state_d == S_PLAY) ? cnt_d[ADDR_W-1:0] : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            len_q    <= '0;
            cnt_q    <= '0;
            gcnt_q   <= '0;
            lead_q   <= '0;
            lag_q    <= '0;
            chen_q   <= '0;
            mode_q   <= 1'b0;
            tx_addr  <= '0;
            tx_valid <= '0;
            pa_en    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            state    <= state_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            gcnt_q   <= gcnt_d;
            lead_q   <= lead_d;
            lag_q    <= lag_d;
            chen_q   <= chen_d;
            mode_q   <= mode_d;
            tx_addr  <= addr_d;
            tx_valid <= valid_d;
            pa_en    <= pa_d;
            busy     <= busy_d;
            done     <= done_d;
            overrun  <= ovr_d;
        end
    end
endmodule

// File: tb/tb_tx_sequencer.sv
// Bench for tx_sequencer: burst-position reference model checked every cycle,
// directed timing checks and randomized trig/abort/mode traffic.
module tb_tx_sequencer;
    localparam int ADDR_W  = 14;
    localparam int NCH     = 2;
    localparam int GUARD_W = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               trig, mode, abort, sysref;
    logic [ADDR_W-1:0]  txsmps;
    logic [GUARD_W-1:0] lead, lag;
    logic [NCH-1:0]     chan_en;
    logic [ADDR_W-1:0]  tx_addr;
    logic [NCH-1:0]     tx_valid;
    logic               pa_en, busy, done, overrun;

    always #5 clk = ~clk;

    tx_sequencer #(.ADDR_W(ADDR_W), .NCH(NCH), .GUARD_W(GUARD_W)) dut (
        .clk(clk), .rst(rst), .trig(trig), .mode(mode), .txsmps(txsmps),
        .lead(lead), .lag(lag), .chan_en(chan_en), .abort(abort), .sysref(sysref),
        .tx_addr(tx_addr), .tx_valid(tx_valid), .pa_en(pa_en), .busy(busy),
        .done(done), .overrun(overrun)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a burst is a timeline indexed by p (cycles since the
    // burst went live): [0,L) lead, [L,end) play, [end,end+G) lag.
    bit             m_act, m_arm, m_done, m_ovr, m_cont;
    int             m_p, m_L, m_G, m_N = 1, m_end;
    logic [NCH-1:0] m_ce;
    logic [4:0]     m_sh;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_act = 0; m_arm = 0; m_done = 0; m_ovr = 0; m_sh = '0;
        end else begin
            bit pulse;
            // Rising edge on sysref becomes usable three edges after it is first sampled.
            pulse  = m_sh[2] & ~m_sh[3];
            m_done = 0;
            m_ovr  = (m_act || m_arm) && trig;
            if (m_act || m_arm) begin
                if (abort) begin
                    m_act = 0; m_arm = 0;
                end else if (m_arm) begin
                    if (pulse) begin m_arm = 0; m_act = 1; m_p = 0; end
                end else begin
                    if (m_cont && mode && m_p == m_end - 1) m_end += m_N;
                    m_p++;
                    if (m_p >= m_end + m_G) begin m_act = 0; m_done = 1; end
                end
            end else if (trig && !abort) begin
                m_L = int'(lead); m_G = int'(lag); m_ce = chan_en; m_cont = mode;
                m_N = (txsmps == 0) ? (1 << ADDR_W) : int'(txsmps);
                m_end = m_L + m_N;
`ifdef TX_SYSREF_ALIGN_EN
                m_arm = 1;
`else
                m_act = 1; m_p = 0;
`endif
            end
            m_sh = {m_sh[3:0], sysref};
        end
    end

    always @(negedge clk) begin
        bit play;
        play = m_act && m_p >= m_L && m_p < m_end;
        chk("m_addr",    tx_addr,  play ? longint'((m_p - m_L) % m_N) : 0);
        chk("m_valid",   tx_valid, play ? longint'(m_ce) : 0);
        chk("m_pa_en",   pa_en,    longint'(m_act));
        chk("m_busy",    busy,     longint'(m_act || m_arm));
        chk("m_done",    done,     longint'(m_done));
        chk("m_overrun", overrun,  longint'(m_ovr));
    end

    initial begin
        int n, last;
        rst = 1; trig = 0; mode = 0; txsmps = '0; lead = '0; lag = '0;
        chan_en = '0; abort = 0; sysref = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_addr", tx_addr, 0);  chk("rst_valid", tx_valid, 0);
        chk("rst_pa", pa_en, 0);      chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);     chk("rst_ovr", overrun, 0);
        tick(); rst = 0;

`ifndef TX_SYSREF_ALIGN_EN
        // One-shot timing; inputs changed mid-burst must not matter.
        tick(); lead = 3; lag = 2; txsmps = 8; chan_en = 2'b01; mode = 0; trig = 1;
        tick(); trig = 0; txsmps = 2; lag = 0; chan_en = 2'b11;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            chk("t1_pa",    pa_en,    (c >= 1 && c <= 13) ? 1 : 0);
            chk("t1_busy",  busy,     (c >= 1 && c <= 13) ? 1 : 0);
            chk("t1_valid", tx_valid, (c >= 4 && c <= 11) ? 1 : 0);
            chk("t1_addr",  tx_addr,  (c >= 4 && c <= 11) ? c - 4 : 0);
            chk("t1_done",  done,     (c == 14) ? 1 : 0);
        end

        // Full-depth burst.
        tick(); txsmps = '0; lead = 0; lag = 0; chan_en = 2'b11; trig = 1;
        tick(); trig = 0;
        n = 0; last = -1;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (tx_valid == 0) break;
            n++; last = int'(tx_addr);
        end
        chk("t2_count", n, 16384);
        chk("t2_last",  last, 16383);
        chk("t2_done",  done, 1);
        chk("t2_busy",  busy, 0);

        // Continuous mode, then drop mode mid-loop.
        tick(); txsmps = 4; lead = 1; lag = 1; mode = 1; chan_en = 2'b10; trig = 1;
        tick(); trig = 0;
        repeat (9) tick();
        mode = 0;
        last = -1; n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx_valid == 0) break;
            last = int'(tx_addr); n++;
        end
        chk("t3_last", last, 3);
        chk("t3_lag_pa", pa_en, 1);
        @(negedge clk);
        chk("t3_done", done, 1);

        // Overrun during LEAD, then abort at address 5.
        tick(); txsmps = 10; lead = 2; lag = 2; chan_en = 2'b01; trig = 1;
        tick(); trig = 1;
        tick(); trig = 0;
        @(negedge clk);
        chk("t4_ovr", overrun, 1);
        chk("t4_busy", busy, 1);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (tx_valid != 0 && tx_addr == 5) begin n = 1; break; end
        end
        chk("t4_reach5", n, 1);
        abort = 1;
        tick(); abort = 0;
        @(negedge clk);
        chk("t4_pa", pa_en, 0); chk("t4_valid", tx_valid, 0);
        chk("t4_busy_off", busy, 0); chk("t4_addr", tx_addr, 0);
        @(negedge clk);
        chk("t4_nodone", done, 0);

        // Trig and abort together in IDLE.
        tick(); trig = 1; abort = 1;
        tick(); trig = 0; abort = 0;
        @(negedge clk);
        chk("t5_busy", busy, 0); chk("t5_ovr", overrun, 0);

        // Async reset mid-PLAY.
        tick(); txsmps = 20; lead = 0; lag = 3; chan_en = 2'b11; trig = 1;
        tick(); trig = 0;
        repeat (5) tick();
        rst = 1; #1;
        chk("t5_rst_pa", pa_en, 0); chk("t5_rst_busy", busy, 0);
        chk("t5_rst_valid", tx_valid, 0); chk("t5_rst_addr", tx_addr, 0);
        tick(); rst = 0;
`else
        // sysref alignment: ARM holds until the synchronised edge.
        tick(); txsmps = 4; lead = 2; lag = 1; chan_en = 2'b01; mode = 0; trig = 1;
        tick(); trig = 0;
        @(negedge clk);
        chk("t6_busy", busy, 1); chk("t6_pa", pa_en, 0);
        repeat (39) tick();
        chk("t6_wait_pa", pa_en, 0);
        sysref = 1;
        n = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (pa_en) begin n = i; break; end
        end
        chk("t6_latency", n, 4);
        sysref = 0;
        repeat (12) tick();
        chk("t6_idle", busy, 0);
`endif

        // Randomized traffic.
        for (int i = 0; i < 5000; i++) begin
            tick();
            trig    = ($urandom_range(0, 19) == 0);
            abort   = ($urandom_range(0, 79) == 0);
            mode    = ($urandom_range(0, 3) != 0);
            txsmps  = ADDR_W'($urandom_range(1, 12));
            lead    = GUARD_W'($urandom_range(0, 4));
            lag     = GUARD_W'($urandom_range(0, 4));
            chan_en = NCH'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) sysref = ~sysref;
        end
        trig = 0; abort = 0; mode = 0;
        n = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (!busy) begin n = 1; break; end
        end
        chk("final_idle", n, 1);
        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
